// File: rtl/shift_sequencer_if.sv
// Command handshake bundle between a command source and shift_sequencer.
// The master drives the command fields, and the slave (the sequencer) returns cmd_ready.
interface shift_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_data;
  logic       cmd_load;
  logic       cmd_dir;
  logic [2:0] cmd_count;
  logic       cmd_fill;
  logic       cmd_rotate;

  modport master (
    output cmd_valid, cmd_data, cmd_load, cmd_dir, cmd_count, cmd_fill, cmd_rotate,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_data, cmd_load, cmd_dir, cmd_count, cmd_fill, cmd_rotate,
    output cmd_ready
  );
endinterface

// File: rtl/shift_sequencer.sv
// Drives a 4-bit universal shift register through an optional load followed by 0-7 single-bit shifts.
// Define SHIFT_SEQ_ROTATE_EN to honour cmd_rotate; without it, shifts always fill with cmd_fill.
module shift_sequencer (
  input  logic               clk,
  input  logic               clear,
  shift_sequencer_if.slave   cmd,
  input  logic [3:0]         reg_out,
  output logic [1:0]         opcode,
  output logic [3:0]         data,
  output logic               input_shift_right,
  output logic               input_shift_left,
  output logic               busy,
  output logic               done,
  output logic [3:0]         result
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_SHR  = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  state_t     state;
  logic [2:0] remaining;
  logic       lat_dir;
  logic       lat_fill;
`ifdef SHIFT_SEQ_ROTATE_EN
  logic       lat_rotate;
`endif
  logic [3:0] result_hold;
  logic       ready_q;
  logic       active_bit;

  function automatic logic [1:0] shift_op(input logic dir);
    return dir ? OP_SHL : OP_SHR;
  endfunction

  // Outputs are registered and assigned alongside the transition into the state that owns them.
  // NOTE: every assignment in a clocked block is non-blocking, so all state updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (clear) begin
      state       <= IDLE;
      remaining   <= 3'd0;
      lat_dir     <= 1'b0;
      lat_fill    <= 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
      lat_rotate  <= 1'b0;
`endif
      data        <= 4'b0000;
      opcode      <= OP_HOLD;
      busy        <= 1'b0;
      done        <= 1'b0;
      ready_q     <= 1'b1;
      result_hold <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          if (cmd.cmd_valid) begin
            data      <= cmd.cmd_data;
            lat_dir   <= cmd.cmd_dir;
            lat_fill  <= cmd.cmd_fill;
`ifdef SHIFT_SEQ_ROTATE_EN
            lat_rotate <= cmd.cmd_rotate;
`endif
            remaining <= cmd.cmd_count;
            busy      <= 1'b1;
            ready_q   <= 1'b0;
            if (cmd.cmd_load) begin
              state  <= LOAD;
              opcode <= OP_LOAD;
            end else if (cmd.cmd_count != 3'd0) begin
              state  <= SHIFT;
              opcode <= shift_op(cmd.cmd_dir);
            end else begin
              state  <= DONE;
              opcode <= OP_HOLD;
              done   <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (remaining != 3'd0) begin
            state  <= SHIFT;
            opcode <= shift_op(lat_dir);
          end else begin
            state  <= DONE;
            opcode <= OP_HOLD;
            done   <= 1'b1;
          end
        end
        SHIFT: begin
          remaining <= remaining - 3'd1;
          // A remaining count of 1 means this cycle performs the last shift.
          if (remaining == 3'd1) begin
            state  <= DONE;
            opcode <= OP_HOLD;
            done   <= 1'b1;
          end
        end
        DONE: begin
          result_hold <= reg_out;
          state       <= IDLE;
          done        <= 1'b0;
          busy        <= 1'b0;
          ready_q     <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Serial inputs: only the side matching the shift direction is driven, and only while shifting.
  // NOTE: outputs get a default first, so no path through this block leaves them unassigned (no latch).
  always_comb begin
    input_shift_right = 1'b0;
    input_shift_left  = 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
    active_bit = lat_rotate ? (lat_dir ? reg_out[3] : reg_out[0]) : lat_fill;
`else
    active_bit = lat_fill;
`endif
    if (state == SHIFT) begin
      if (lat_dir) input_shift_left  = active_bit;
      else         input_shift_right = active_bit;
    end
  end

  assign result        = (state == DONE) ? reg_out : result_hold;
  assign cmd.cmd_ready = ready_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural 4-bit universal shift register attached.
// Rotate expectations follow SHIFT_SEQ_ROTATE_EN as defined for the build.
`timescale 1ns/1ps
module tb_shift_sequencer;
  logic       clk;
  logic       clear;
  logic [3:0] reg_out;
  logic [1:0] opcode;
  logic [3:0] data;
  logic       isr, isl, busy, done;
  logic [3:0] result;

  shift_sequencer_if ifc ();

  shift_sequencer dut (
    .clk               (clk),
    .clear             (clear),
    .cmd               (ifc.slave),
    .reg_out           (reg_out),
    .opcode            (opcode),
    .data              (data),
    .input_shift_right (isr),
    .input_shift_left  (isl),
    .busy              (busy),
    .done              (done),
    .result            (result)
  );

  // Downstream universal shift register sharing clk and clear.
  logic [3:0] sr_q;
  always @(posedge clk) begin
    if (clear) sr_q <= 4'b0000;
    else begin
      case (opcode)
        2'b01:   sr_q <= {isr, sr_q[3:1]};
        2'b10:   sr_q <= {sr_q[2:0], isl};
        2'b11:   sr_q <= data;
        default: sr_q <= sr_q;
      endcase
    end
  end
  assign reg_out = sr_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int         n_cycles;
  logic       got_done;
  logic [3:0] done_result;
  logic [1:0] op_trace [20];
  logic       isl_trace[20];
  logic       isr_trace[20];
  logic [3:0] exp7;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one command from IDLE, records per-cycle outputs until done (bounded), then returns to IDLE.
  task automatic send(input logic [3:0] d, input logic ld, input logic dr, input logic [2:0] cnt,
                      input logic fl, input logic rt);
    ifc.cmd_data = d; ifc.cmd_load = ld; ifc.cmd_dir = dr;
    ifc.cmd_count = cnt; ifc.cmd_fill = fl; ifc.cmd_rotate = rt;
    ifc.cmd_valid = 1'b1;
    tick();
    ifc.cmd_valid = 1'b0;
    n_cycles = 0;
    got_done = 1'b0;
    done_result = 4'bxxxx;
    for (int i = 0; i < 20 && !got_done; i++) begin
      op_trace[i]  = opcode;
      isl_trace[i] = isl;
      isr_trace[i] = isr;
      n_cycles     = i + 1;
      if (done === 1'b1) begin
        got_done    = 1'b1;
        done_result = result;
      end else tick();
    end
    tick();
  endtask

  task automatic test_reset();
    clear = 1'b1;
    ifc.cmd_valid = 1'b0; ifc.cmd_data = 4'b0000; ifc.cmd_load = 1'b0; ifc.cmd_dir = 1'b0;
    ifc.cmd_count = 3'd0; ifc.cmd_fill = 1'b0; ifc.cmd_rotate = 1'b0;
    tick(); tick();
    checks++; if (opcode !== 2'b00) begin failures++; $display("FAIL reset_opcode got=%b exp=00", opcode); end
    checks++; if (data !== 4'b0000) begin failures++; $display("FAIL reset_data got=%b exp=0000", data); end
    checks++; if ({isr, isl} !== 2'b00) begin failures++; $display("FAIL reset_serial got=%b exp=00", {isr, isl}); end
    checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL reset_busy_done got=%b exp=00", {busy, done}); end
    checks++; if (result !== 4'b0000) begin failures++; $display("FAIL reset_result got=%b exp=0000", result); end
    checks++; if (ifc.cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ifc.cmd_ready); end
    clear = 1'b0;
  endtask

  task automatic test_load_shift_right();
    send(4'b1100, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0);
    checks++; if (got_done !== 1'b1 || n_cycles != 3) begin failures++; $display("FAIL ldsr_latency got=%0d exp=3", n_cycles); end
    checks++; if (done_result !== 4'b0110) begin failures++; $display("FAIL ldsr_result got=%b exp=0110", done_result); end
    checks++; if ({op_trace[0], op_trace[1], op_trace[2]} !== 6'b11_01_00) begin failures++;
      $display("FAIL ldsr_opseq got=%b_%b_%b exp=11_01_00", op_trace[0], op_trace[1], op_trace[2]); end
    checks++; if ({done, busy, ifc.cmd_ready} !== 3'b001) begin failures++; $display("FAIL ldsr_after got=%b exp=001", {done, busy, ifc.cmd_ready}); end
    checks++; if (result !== 4'b0110) begin failures++; $display("FAIL ldsr_held got=%b exp=0110", result); end
  endtask

  task automatic test_shift_left_fill();
    send(4'b0011, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    checks++; if (got_done !== 1'b1 || n_cycles != 2) begin failures++; $display("FAIL ld0_latency got=%0d exp=2", n_cycles); end
    checks++; if (done_result !== 4'b0011) begin failures++; $display("FAIL ld0_result got=%b exp=0011", done_result); end
    send(4'b0000, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0);
    checks++; if (got_done !== 1'b1 || n_cycles != 3) begin failures++; $display("FAIL shl_latency got=%0d exp=3", n_cycles); end
    checks++; if (done_result !== 4'b1111) begin failures++; $display("FAIL shl_result got=%b exp=1111", done_result); end
    checks++; if ({isl_trace[0], isl_trace[1], isl_trace[2]} !== 3'b110) begin failures++;
      $display("FAIL shl_isl got=%b exp=110", {isl_trace[0], isl_trace[1], isl_trace[2]}); end
    checks++; if ({isr_trace[0], isr_trace[1]} !== 2'b00) begin failures++; $display("FAIL shl_isr got=%b exp=00", {isr_trace[0], isr_trace[1]}); end
    checks++; if ({op_trace[0], op_trace[1]} !== 4'b10_10) begin failures++; $display("FAIL shl_opseq got=%b_%b exp=10_10", op_trace[0], op_trace[1]); end
  endtask

  task automatic test_rotate();
    logic [3:0] exp_a, exp_b;
`ifdef SHIFT_SEQ_ROTATE_EN
    exp_a = 4'b1000; exp_b = 4'b0011; exp7 = 4'b0011;
`else
    exp_a = 4'b0000; exp_b = 4'b0010; exp7 = 4'b1111;
`endif
    send(4'b0001, 1'b1, 1'b0, 3'd5, 1'b0, 1'b1);
    checks++; if (got_done !== 1'b1 || n_cycles != 7) begin failures++; $display("FAIL rotr5_latency got=%0d exp=7", n_cycles); end
    checks++; if (done_result !== exp_a) begin failures++; $display("FAIL rotr5_result got=%b exp=%b", done_result, exp_a); end
    send(4'b1001, 1'b1, 1'b1, 3'd1, 1'b0, 1'b1);
    checks++; if (done_result !== exp_b) begin failures++; $display("FAIL rotl1_result got=%b exp=%b", done_result, exp_b); end
    send(4'b0110, 1'b1, 1'b1, 3'd7, 1'b1, 1'b1);
    checks++; if (got_done !== 1'b1 || n_cycles != 9) begin failures++; $display("FAIL rotl7_latency got=%0d exp=9", n_cycles); end
    checks++; if (done_result !== exp7) begin failures++; $display("FAIL rotl7_result got=%b exp=%b", done_result, exp7); end
  endtask

  task automatic test_count_zero();
    send(4'b0101, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    checks++; if (got_done !== 1'b1 || n_cycles != 1) begin failures++; $display("FAIL cnt0_latency got=%0d exp=1", n_cycles); end
    checks++; if (done_result !== exp7) begin failures++; $display("FAIL cnt0_result got=%b exp=%b", done_result, exp7); end
    checks++; if (op_trace[0] !== 2'b00 || opcode !== 2'b00) begin failures++; $display("FAIL cnt0_opcode got=%b exp=00", op_trace[0]); end
    checks++; if (data !== 4'b0101) begin failures++; $display("FAIL cnt0_data got=%b exp=0101", data); end
  endtask

  task automatic test_clear_abort();
    logic seen_done;
    seen_done = 1'b0;
    ifc.cmd_data = 4'b1010; ifc.cmd_load = 1'b1; ifc.cmd_dir = 1'b0;
    ifc.cmd_count = 3'd4; ifc.cmd_fill = 1'b1; ifc.cmd_rotate = 1'b0;
    ifc.cmd_valid = 1'b1;
    tick();
    checks++; if ({opcode, busy, ifc.cmd_ready} !== 4'b11_1_0) begin failures++; $display("FAIL clr_load got=%b exp=1110", {opcode, busy, ifc.cmd_ready}); end
    tick();
    tick();
    checks++; if ({opcode, isr, isl} !== 4'b01_1_0) begin failures++; $display("FAIL clr_shift2 got=%b exp=0110", {opcode, isr, isl}); end
    clear = 1'b1;
    tick();
    seen_done |= done;
    checks++; if ({ifc.cmd_ready, busy, opcode} !== 4'b1_0_00) begin failures++; $display("FAIL clr_idle got=%b exp=1000", {ifc.cmd_ready, busy, opcode}); end
    checks++; if (result !== 4'b0000 || data !== 4'b0000) begin failures++; $display("FAIL clr_values got=%b/%b exp=0000/0000", result, data); end
    tick();
    seen_done |= done;
    checks++; if ({ifc.cmd_ready, busy} !== 2'b10) begin failures++; $display("FAIL clr_wins got=%b exp=10", {ifc.cmd_ready, busy}); end
    clear = 1'b0;
    tick();
    checks++; if (seen_done !== 1'b0) begin failures++; $display("FAIL clr_no_done got=%b exp=0", seen_done); end
    checks++; if ({busy, ifc.cmd_ready, opcode} !== 4'b1_0_11) begin failures++; $display("FAIL clr_accept got=%b exp=1011", {busy, ifc.cmd_ready, opcode}); end
    ifc.cmd_valid = 1'b0;
    got_done = 1'b0;
    for (int i = 0; i < 20 && !got_done; i++) begin
      if (done === 1'b1) begin got_done = 1'b1; done_result = result; end
      else tick();
    end
    checks++; if (got_done !== 1'b1 || done_result !== 4'b1111) begin failures++; $display("FAIL clr_rerun got=%b exp=1111", done_result); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [2:0] pattern;
    ifc.cmd_load = 1'b0; ifc.cmd_count = 3'd0; ifc.cmd_dir = 1'b0; ifc.cmd_data = 4'b0000;
    ifc.cmd_valid = 1'b1;
    tick(); pattern[2] = done;
    checks++; if (result !== 4'b1111) begin failures++; $display("FAIL b2b_result got=%b exp=1111", result); end
    tick(); pattern[1] = done;
    checks++; if (ifc.cmd_ready !== 1'b1) begin failures++; $display("FAIL b2b_idle_ready got=%b exp=1", ifc.cmd_ready); end
    tick(); pattern[0] = done;
    ifc.cmd_valid = 1'b0;
    checks++; if (pattern !== 3'b101) begin failures++; $display("FAIL b2b_done_pattern got=%b exp=101", pattern); end
    tick();
  endtask

  initial begin
    test_reset();
    test_load_shift_right();
    test_shift_left_fill();
    test_rotate();
    test_count_zero();
    test_clear_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
